mem_access_ctrl: RTL

Data-memory access controller between the load/store execute stage and the 32-bit data bus. It accepts one byte, halfword or word request, maps it onto word-aligned bus beats with byte strobes, and splits accesses that cross a word boundary into two beats. For reads it returns right-justified, zero-extended data; every request completes with a single-cycle ready pulse.

---
 rtl/mem_access_ctrl_pkg.sv | 25 ++
 rtl/mem_access_ctrl_if.sv | 21 ++
 rtl/mem_lane_align.sv | 29 ++
 rtl/mem_access_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes and FSM states.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BEAT0   = 3'd1,
    BEAT1   = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Size code 3 falls through to a full word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = 4'h1;
      SZ_HALF: size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-aligned data bus between the access controller (master) and memory (slave).
interface mem_access_ctrl_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_we;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane placement for stores and right-justified extraction for loads over a two-word window.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  strb,
  output logic [63:0] wdata_vec,
  output logic        split,
  output logic [31:0] rd_ext
);
  logic [4:0]  sh;
  logic [31:0] rd_shift;

  always_comb begin
    sh        = {off, 3'b000};
    strb      = {4'b0000, size_mask(size)} << off;
    wdata_vec = {32'h0, wdata} << sh;
    split     = |strb[7:4];
    rd_shift  = 32'(rdata >> sh);
    case (size)
      SZ_BYTE: rd_ext = {24'h0, rd_shift[7:0]};
      SZ_HALF: rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store to 32-bit bus access controller: one or two aligned beats per request, single-cycle completion pulse.
//  state   | meaning
//  IDLE    | waiting for a read/write request level
//  BEAT0   | first (or only) bus beat outstanding
//  BEAT1   | second beat of a word-crossing access outstanding
//  RESP    | ready (and err) pulse visible
//  RELEASE | waiting for both request levels to drop
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  output logic [31:0] rd_data,
  output logic        rd_ready,
  output logic        wr_ready,
  output logic        err,
  mem_access_ctrl_if.master bus
);
  state_t      state_q, state_n;
  logic [1:0]  off_q, off_n, size_q, size_n;
  logic [31:0] wdata_q, wdata_n, lo_q, lo_n;
  logic        op_wr_q, op_wr_n;
  logic [31:0] rd_data_n;
  logic        rd_ready_n, wr_ready_n, err_n;
  logic [31:0] baddr_q, baddr_n, bwdata_q, bwdata_n;
  logic [3:0]  bstrb_q, bstrb_n;
  logic        bwe_q, bwe_n, bvalid_q, bvalid_n;
  logic        idle, handshake, finish, fin_err;

  logic [1:0]  al_off, al_size;
  logic [31:0] al_wdata, al_rd;
  logic [63:0] al_rdata, al_wvec;
  logic [7:0]  al_strb;
  logic        al_split;

  // In IDLE the first beat is built straight from the request so bus_valid can rise one cycle later.
  assign idle      = (state_q == IDLE);
  assign al_off    = idle ? req_addr[1:0] : off_q;
  assign al_size   = idle ? req_size      : size_q;
  assign al_wdata  = idle ? req_wdata     : wdata_q;
  assign al_rdata  = (state_q == BEAT1) ? {bus.bus_rdata, lo_q} : {32'h0, bus.bus_rdata};
  assign handshake = bvalid_q && bus.bus_ready;

  mem_lane_align u_align (
    .off       (al_off),
    .size      (al_size),
    .wdata     (al_wdata),
    .rdata     (al_rdata),
    .strb      (al_strb),
    .wdata_vec (al_wvec),
    .split     (al_split),
    .rd_ext    (al_rd)
  );

  always_comb begin
    state_n    = state_q;
    off_n      = off_q;
    size_n     = size_q;
    wdata_n    = wdata_q;
    op_wr_n    = op_wr_q;
    lo_n       = lo_q;
    rd_data_n  = rd_data;
    rd_ready_n = 1'b0;
    wr_ready_n = 1'b0;
    err_n      = 1'b0;
    baddr_n    = baddr_q;
    bwdata_n   = bwdata_q;
    bstrb_n    = bstrb_q;
    bwe_n      = bwe_q;
    bvalid_n   = bvalid_q;
    finish     = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_wr_en || req_rd_en) begin
          off_n    = req_addr[1:0];
          size_n   = req_size;
          wdata_n  = req_wdata;
          op_wr_n  = req_wr_en;
          baddr_n  = {req_addr[31:2], 2'b00};
          bwdata_n = al_wvec[31:0];
          bstrb_n  = req_wr_en ? al_strb[3:0] : 4'h0;
          bwe_n    = req_wr_en;
          bvalid_n = 1'b1;
          state_n  = BEAT0;
        end
      end
      BEAT0: begin
        if (handshake) begin
          lo_n = bus.bus_rdata;
          if (al_split && !bus.bus_err) begin
            baddr_n  = baddr_q + 32'd4;
            bwdata_n = al_wvec[63:32];
            bstrb_n  = op_wr_q ? al_strb[7:4] : 4'h0;
            state_n  = BEAT1;
          end else begin
            finish  = 1'b1;
            fin_err = bus.bus_err;
          end
        end
      end
      BEAT1: begin
        if (handshake) begin
          finish  = 1'b1;
          fin_err = bus.bus_err;
        end
      end
      RESP:    state_n = RELEASE;
      RELEASE: if (!req_rd_en && !req_wr_en) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (finish) begin
      state_n    = RESP;
      bvalid_n   = 1'b0;
      rd_ready_n = !op_wr_q;
      wr_ready_n = op_wr_q;
      err_n      = fin_err;
      if (!op_wr_q) rd_data_n = fin_err ? 32'h0 : al_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      off_q    <= 2'b00;
      size_q   <= SZ_WORD;
      wdata_q  <= 32'h0;
      op_wr_q  <= 1'b0;
      lo_q     <= 32'h0;
      rd_data  <= 32'h0;
      rd_ready <= 1'b0;
      wr_ready <= 1'b0;
      err      <= 1'b0;
      baddr_q  <= 32'h0;
      bwdata_q <= 32'h0;
      bstrb_q  <= 4'h0;
      bwe_q    <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      off_q    <= off_n;
      size_q   <= size_n;
      wdata_q  <= wdata_n;
      op_wr_q  <= op_wr_n;
      lo_q     <= lo_n;
      rd_data  <= rd_data_n;
      rd_ready <= rd_ready_n;
      wr_ready <= wr_ready_n;
      err      <= err_n;
      baddr_q  <= baddr_n;
      bwdata_q <= bwdata_n;
      bstrb_q  <= bstrb_n;
      bwe_q    <= bwe_n;
      bvalid_q <= bvalid_n;
    end
  end

  assign bus.bus_addr  = baddr_q;
  assign bus.bus_wdata = bwdata_q;
  assign bus.bus_wstrb = bstrb_q;
  assign bus.bus_we    = bwe_q;
  assign bus.bus_valid = bvalid_q;
endmodule
